// File: rtl/rot_seq_pkg.sv
// Shared types for the rotate command sequencer: FSM state encoding and the
// first-state decision used when a command is taken.
package rot_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ROT  = 2'd2,
    DONE = 2'd3
  } seq_state_t;

  // A command with neither load nor rotate still owes its done pulse.
  function automatic seq_state_t first_state(input logic load, input logic rot_pending);
    if (load)
      return LOAD;
    if (rot_pending)
      return ROT;
    return DONE;
  endfunction

endpackage

// File: rtl/rot_cmd_fifo.sv
// Synchronous command FIFO (first-word view on rd_data), async active-low reset.
// Only compiled when ROT_CMD_SEQ_FIFO_EN is defined.
`ifdef ROT_CMD_SEQ_FIFO_EN
module rot_cmd_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] wr_data,
  input  logic         pop,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= bump(wr_ptr);
      if (do_pop)
        rd_ptr <= bump(rd_ptr);
      if (do_push && !do_pop)
        count <= count + CW'(1);
      else if (do_pop && !do_push)
        count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= wr_data;
  end

endmodule
`endif

// File: rtl/rot_cmd_seq.sv
// Rotate command sequencer: turns {load, dir, amount, data} commands into
// load/enable strobes for a downstream rotate register and tracks its content.
// Optional command queue enabled by defining ROT_CMD_SEQ_FIFO_EN.
module rot_cmd_seq
  import rot_seq_pkg::*;
#(
  parameter int N          = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_load,
  input  logic                 cmd_right,
  input  logic [$clog2(N)-1:0] cmd_amt,
  input  logic [N-1:0]         cmd_data,
  output logic                 sr_load,
  output logic                 sr_en,
  output logic                 sr_right,
  output logic [N-1:0]         sr_data,
  output logic                 busy,
  output logic                 done,
  output logic [N-1:0]         shadow
);

  localparam int CNT_W = $clog2(N);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef struct packed {
    logic             load;
    logic             right;
    logic [CNT_W-1:0] amt;
    logic [N-1:0]     data;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

  if ((N < 2) || ((N & (N - 1)) != 0) || (FIFO_DEPTH < 1)) begin : g_bad_param
    $error("rot_cmd_seq: N must be a power of two >= 2 and FIFO_DEPTH >= 1");
  end

  seq_state_t       state;
  seq_state_t       state_nx;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             run_q;
  logic             take;
  cmd_t             cmd_in;
  cmd_t             new_cmd;
  logic             cur_right;
  logic [CNT_W-1:0] cur_amt;
  logic             act_right;

  function automatic logic [N-1:0] rot1(input logic [N-1:0] v, input logic right);
    return right ? {v[0], v[N-1:1]} : {v[N-2:0], v[N-1]};
  endfunction

  assign cmd_in = '{load: cmd_load, right: cmd_right, amt: cmd_amt, data: cmd_data};

`ifdef ROT_CMD_SEQ_FIFO_EN
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic [CMD_W-1:0] fifo_rd;

  // Popping in DONE lets the next command start without an IDLE gap.
  assign cmd_ready = run_q & ~fifo_full;
  assign push      = cmd_valid & cmd_ready;
  assign pop       = run_q & ~fifo_empty & ((state == IDLE) | (state == DONE));
  assign take      = pop;
  assign new_cmd   = cmd_t'(fifo_rd);

  rot_cmd_fifo #(
    .W     (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .wr_data (CMD_W'(cmd_in)),
    .pop     (pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );
`else
  assign cmd_ready = run_q & (state == IDLE);
  assign take      = cmd_valid & cmd_ready;
  assign new_cmd   = cmd_in;
`endif

  assign act_right = take ? new_cmd.right : cur_right;

  always_comb begin
    state_nx = state;
    cnt_d    = cnt_q;
    unique case (state)
      IDLE, DONE: begin
        state_nx = IDLE;
        if (take) begin
          state_nx = first_state(new_cmd.load, new_cmd.amt != '0);
          cnt_d    = new_cmd.amt;
        end
      end
      LOAD: begin
        state_nx = (cur_amt != '0) ? ROT : DONE;
      end
      ROT: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE)
          state_nx = DONE;
      end
    endcase
  end

  // Strobes are registered from the next state so they line up with the FSM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt_q    <= '0;
      run_q    <= 1'b0;
      sr_load  <= 1'b0;
      sr_en    <= 1'b0;
      sr_right <= 1'b0;
      sr_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      shadow   <= '0;
    end else begin
      state    <= state_nx;
      cnt_q    <= cnt_d;
      run_q    <= 1'b1;
      sr_load  <= (state_nx == LOAD);
      sr_en    <= (state_nx == LOAD) | (state_nx == ROT);
      sr_right <= (state_nx == ROT) & act_right;
      if (state_nx == LOAD)
        sr_data <= new_cmd.data;
      busy     <= (state_nx != IDLE);
      done     <= (state_nx == DONE);
      // Mirror what the downstream register samples on this same edge.
      if (sr_en)
        shadow <= sr_load ? sr_data : rot1(shadow, sr_right);
    end
  end

  always_ff @(posedge clk) begin
    if (take) begin
      cur_right <= new_cmd.right;
      cur_amt   <= new_cmd.amt;
    end
  end

endmodule

// File: tb/tb_rot_cmd_seq.sv
// Directed self-checking bench for rot_cmd_seq (N=8); the queued-command
// scenario is included when ROT_CMD_SEQ_FIFO_EN is defined.
module tb_rot_cmd_seq;

`ifdef ROT_CMD_SEQ_FIFO_EN
  localparam int Q_LAT = 1;
`else
  localparam int Q_LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_load;
  logic       cmd_right;
  logic [2:0] cmd_amt;
  logic [7:0] cmd_data;
  logic       sr_load;
  logic       sr_en;
  logic       sr_right;
  logic [7:0] sr_data;
  logic       busy;
  logic       done;
  logic [7:0] shadow;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] model_sh;
  logic [7:0] sh_log [1:16];

  rot_cmd_seq #(.N(8), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_load  (cmd_load),
    .cmd_right (cmd_right),
    .cmd_amt   (cmd_amt),
    .cmd_data  (cmd_data),
    .sr_load   (sr_load),
    .sr_en     (sr_en),
    .sr_right  (sr_right),
    .sr_data   (sr_data),
    .busy      (busy),
    .done      (done),
    .shadow    (shadow)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rot_model(input logic [7:0] v, input logic rt);
    return rt ? ((v >> 1) | (v << 7)) : ((v << 1) | (v >> 7));
  endfunction

  task automatic chk_all_zero(input string nm);
    chk({nm, ".sr_load"}, sr_load, 0);
    chk({nm, ".sr_en"}, sr_en, 0);
    chk({nm, ".sr_right"}, sr_right, 0);
    chk({nm, ".sr_data"}, sr_data, 0);
    chk({nm, ".busy"}, busy, 0);
    chk({nm, ".done"}, done, 0);
    chk({nm, ".shadow"}, shadow, 0);
    chk({nm, ".cmd_ready"}, cmd_ready, 0);
  endtask

  // Offer one command and check every cycle until the done pulse has passed.
  task automatic run_cmd(input string nm, input logic ld, input logic rt,
                         input int amt, input logic [7:0] dat);
    int n;
    int lat;
    logic is_ld;
    logic is_rot;
    cmd_valid = 1'b1;
    cmd_load  = ld;
    cmd_right = rt;
    cmd_amt   = 3'(amt);
    cmd_data  = dat;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("%s.ready", nm), cmd_ready, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_load  = ~ld;
    cmd_right = ~rt;
    cmd_amt   = ~cmd_amt;
    cmd_data  = ~dat;
    if (Q_LAT != 0) begin
      @(posedge clk);
      #1;
    end
    lat = (ld ? 1 : 0) + amt + 1;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      is_ld  = ld && (k == 1);
      is_rot = !is_ld && (k < lat);
      chk($sformatf("%s.c%0d.sr_load", nm, k), sr_load, 32'(is_ld));
      chk($sformatf("%s.c%0d.sr_en", nm, k), sr_en, 32'(is_ld | is_rot));
      chk($sformatf("%s.c%0d.sr_right", nm, k), sr_right, 32'(is_rot & rt));
      chk($sformatf("%s.c%0d.busy", nm, k), busy, 1);
      chk($sformatf("%s.c%0d.done", nm, k), done, 32'(k == lat));
      chk($sformatf("%s.c%0d.shadow", nm, k), shadow, 32'(model_sh));
      if (is_ld)
        chk($sformatf("%s.c%0d.sr_data", nm, k), sr_data, 32'(dat));
      sh_log[k] = shadow;
      if (is_ld)
        model_sh = dat;
      else if (is_rot)
        model_sh = rot_model(model_sh, rt);
    end
    @(negedge clk);
    chk($sformatf("%s.post.done", nm), done, 0);
    chk($sformatf("%s.post.busy", nm), busy, 0);
  endtask

  initial begin
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_load  = 1'b0;
    cmd_right = 1'b0;
    cmd_amt   = '0;
    cmd_data  = '0;
    model_sh  = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("rst");
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst.rel.cmd_ready", cmd_ready, 1);
    chk("rst.rel.shadow", shadow, 0);

    // Load 0xAC then rotate right 3
    run_cmd("ld_r3", 1'b1, 1'b1, 3, 8'hAC);
    chk("ld_r3.sh2", sh_log[2], 8'hAC);
    chk("ld_r3.sh3", sh_log[3], 8'h56);
    chk("ld_r3.sh4", sh_log[4], 8'h2B);
    chk("ld_r3.sh5", sh_log[5], 8'h95);

    // Rotate left 4 from 0x95
    run_cmd("l4", 1'b0, 1'b0, 4, 8'h00);
    chk("l4.final", shadow, 8'h59);

    // No load, zero amount: done only
    run_cmd("nop", 1'b0, 1'b1, 0, 8'hFF);
    chk("nop.final", shadow, 8'h59);

    // Reset during the second ROT cycle
    cmd_valid = 1'b1;
    cmd_load  = 1'b1;
    cmd_right = 1'b0;
    cmd_amt   = 3'd5;
    cmd_data  = 8'h3C;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    if (Q_LAT != 0) begin
      @(posedge clk);
      #1;
    end
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("abort.pre.sr_en", sr_en, 1);
    chk("abort.pre.sr_load", sr_load, 0);
    reset_n = 1'b0;
    #1;
    chk_all_zero("abort");
    repeat (2) begin
      @(negedge clk);
      chk("abort.hold.done", done, 0);
    end
    reset_n  = 1'b1;
    model_sh = '0;
    @(posedge clk);
    #1;
    chk("abort.rel.ready", cmd_ready, 1);
    run_cmd("after", 1'b1, 1'b1, 1, 8'h81);
    chk("after.final", shadow, 8'hC0);

`ifdef ROT_CMD_SEQ_FIFO_EN
    begin
      logic       q_ld [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      logic       q_rt [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      int         q_am [5] = '{7, 3, 5, 7, 6};
      logic [7:0] q_dt [5] = '{8'hAC, 8'h00, 8'h0F, 8'h00, 8'h81};
      logic [7:0] q_exp [5];
      int         j;
      int         n;
      for (int i = 0; i < 5; i++) begin
        if (q_ld[i])
          model_sh = q_dt[i];
        for (int r = 0; r < q_am[i]; r++)
          model_sh = rot_model(model_sh, q_rt[i]);
        q_exp[i] = model_sh;
      end
      for (int i = 0; i < 5; i++) begin
        cmd_valid = 1'b1;
        cmd_load  = q_ld[i];
        cmd_right = q_rt[i];
        cmd_amt   = 3'(q_am[i]);
        cmd_data  = q_dt[i];
        chk($sformatf("fifo.push%0d.ready", i), cmd_ready, 1);
        @(posedge clk);
        #1;
      end
      cmd_valid = 1'b0;
      chk("fifo.full.ready", cmd_ready, 0);
      j = 0;
      n = 0;
      while (j < 5 && n < 300) begin
        @(negedge clk);
        n++;
        if (done) begin
          chk($sformatf("fifo.cmd%0d.shadow", j), shadow, 32'(q_exp[j]));
          j++;
        end
      end
      chk("fifo.done_count", j, 5);
      @(negedge clk);
      chk("fifo.idle.busy", busy, 0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
